fpu_sequencer: RTL and testbench



---
 rtl/fpu_seq_pkg.sv | 33 +++
 rtl/fpu_watchdog.sv | 41 ++++
 rtl/fpu_sequencer.sv | 149 ++++++++++++++
 tb/tb_fpu_sequencer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_seq_pkg
//  Description : Shared types and constants for the FPU command sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package fpu_seq_pkg;

    localparam int E_W          = 7;
    localparam int M_W          = 15;
    localparam int DEF_START_TO = 8;
    localparam int DEF_DONE_TO  = 16;

    typedef enum logic [1:0] {
        LOAD1 = 2'b00,
        LOAD2 = 2'b01,
        ADD   = 2'b10,
        SUB   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_watchdog
//  Description : Saturating per-state cycle counter with two selectable
//                limits; flags when the current state has used its budget.
//  Revision    : 1.0  initial release
// ============================================================================
module fpu_watchdog
    import fpu_seq_pkg::*;
#(
    parameter int START_TO = DEF_START_TO,
    parameter int DONE_TO  = DEF_DONE_TO
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic sel_done,
    output logic timeout
);

    localparam int c_CNT_W = $clog2(max_int(START_TO, DONE_TO)) + 1;
    // Timeout fires in the last allowed cycle, so the exit edge is the one
    // on which the count would reach the limit.
    localparam logic [c_CNT_W-1:0] c_START_LAST = c_CNT_W'(START_TO - 1);
    localparam logic [c_CNT_W-1:0] c_DONE_LAST  = c_CNT_W'(DONE_TO - 1);

    logic [c_CNT_W-1:0] r_cnt;

    // Count cycles in the current state; restart on clear, hold at all-ones
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign timeout = sel_done ? (r_cnt == c_DONE_LAST) : (r_cnt == c_START_LAST);

endmodule
`default_nettype wire

// File: rtl/fpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_sequencer
//  Description : Command front-end for the FP adder/subtractor. Holds the
//                R1/R2 operands, issues add/sub strobes, tracks fpu_idle,
//                writes the result back into R1 and guards with a watchdog.
//  Revision    : 1.0  initial release
// ============================================================================
module fpu_sequencer
    import fpu_seq_pkg::*;
#(
    parameter int E_W      = fpu_seq_pkg::E_W,
    parameter int M_W      = fpu_seq_pkg::M_W,
    parameter int START_TO = DEF_START_TO,
    parameter int DONE_TO  = DEF_DONE_TO
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [1:0]     cmd_op,
    input  logic [E_W-1:0] cmd_e,
    input  logic [M_W-1:0] cmd_m,
    output logic           fpu_add,
    output logic           fpu_sub,
    output logic [E_W-1:0] fpu_r1_e,
    output logic [M_W-1:0] fpu_r1_m,
    output logic [E_W-1:0] fpu_r2_e,
    output logic [M_W-1:0] fpu_r2_m,
    input  logic [E_W-1:0] fpu_res_e,
    input  logic [M_W-1:0] fpu_res_m,
    input  logic           fpu_idle,
    output logic           res_valid,
    output logic [E_W-1:0] res_e,
    output logic [M_W-1:0] res_m,
    output logic           busy,
    output logic           err
);

    state_t         r_state;
    logic [E_W-1:0] r_r1_e;
    logic [M_W-1:0] r_r1_m;
    logic [E_W-1:0] r_r2_e;
    logic [M_W-1:0] r_r2_m;
    logic           w_timeout;
    logic           w_wd_clear;
    logic           w_wd_sel_done;

    assign cmd_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign fpu_r1_e  = r_r1_e;
    assign fpu_r1_m  = r_r1_m;
    assign fpu_r2_e  = r_r2_e;
    assign fpu_r2_m  = r_r2_m;

    // The counter is held at zero outside the watched states, so entering
    // ISSUE starts from zero; leaving ISSUE clears it again for WAIT.
    assign w_wd_clear    = (r_state == IDLE) || (r_state == WRITE) ||
                           ((r_state == ISSUE) && !fpu_idle);
    assign w_wd_sel_done = (r_state == WAIT);

    fpu_watchdog #(
        .START_TO (START_TO),
        .DONE_TO  (DONE_TO)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_wd_clear),
        .sel_done (w_wd_sel_done),
        .timeout  (w_timeout)
    );

    // Command FSM with operand/result registers and registered FPU strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_r1_e    <= '0;
            r_r1_m    <= '0;
            r_r2_e    <= '0;
            r_r2_m    <= '0;
            fpu_add   <= 1'b0;
            fpu_sub   <= 1'b0;
            res_valid <= 1'b0;
            res_e     <= '0;
            res_m     <= '0;
            err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        case (op_t'(cmd_op))
                            LOAD1: begin
                                r_r1_e <= cmd_e;
                                r_r1_m <= cmd_m;
                            end
                            LOAD2: begin
                                r_r2_e <= cmd_e;
                                r_r2_m <= cmd_m;
                            end
                            ADD: begin
                                fpu_add <= 1'b1;
                                r_state <= ISSUE;
                            end
                            SUB: begin
                                fpu_sub <= 1'b1;
                                r_state <= ISSUE;
                            end
                            default: ;
                        endcase
                    end
                end
                ISSUE: begin
                    // Drop the strobe as soon as the FPU is seen busy so it is
                    // already low when the FPU returns to idle.
                    if (!fpu_idle) begin
                        fpu_add <= 1'b0;
                        fpu_sub <= 1'b0;
                        r_state <= WAIT;
                    end else if (w_timeout) begin
                        fpu_add <= 1'b0;
                        fpu_sub <= 1'b0;
                        err     <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                WAIT: begin
                    if (fpu_idle) begin
                        r_r1_e    <= fpu_res_e;
                        r_r1_m    <= fpu_res_m;
                        res_e     <= fpu_res_e;
                        res_m     <= fpu_res_m;
                        res_valid <= 1'b1;
                        r_state   <= WRITE;
                    end else if (w_timeout) begin
                        err     <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                WRITE: begin
                    res_valid <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_sequencer
//  Description : Self-checking bench for fpu_sequencer with a behavioural
//                FPU stub (real, stuck-idle, stuck-busy) and a phase model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fpu_sequencer;

    localparam int E_W      = 7;
    localparam int M_W      = 15;
    localparam int START_TO = 8;
    localparam int DONE_TO  = 16;

    logic           clk;
    logic           reset;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd_op;
    logic [E_W-1:0] cmd_e;
    logic [M_W-1:0] cmd_m;
    logic           fpu_add;
    logic           fpu_sub;
    logic [E_W-1:0] fpu_r1_e;
    logic [M_W-1:0] fpu_r1_m;
    logic [E_W-1:0] fpu_r2_e;
    logic [M_W-1:0] fpu_r2_m;
    logic [E_W-1:0] fpu_res_e;
    logic [M_W-1:0] fpu_res_m;
    logic           fpu_idle;
    logic           res_valid;
    logic [E_W-1:0] res_e;
    logic [M_W-1:0] res_m;
    logic           busy;
    logic           err;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    fpu_sequencer #(
        .E_W      (E_W),
        .M_W      (M_W),
        .START_TO (START_TO),
        .DONE_TO  (DONE_TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_e     (cmd_e),
        .cmd_m     (cmd_m),
        .fpu_add   (fpu_add),
        .fpu_sub   (fpu_sub),
        .fpu_r1_e  (fpu_r1_e),
        .fpu_r1_m  (fpu_r1_m),
        .fpu_r2_e  (fpu_r2_e),
        .fpu_r2_m  (fpu_r2_m),
        .fpu_res_e (fpu_res_e),
        .fpu_res_m (fpu_res_m),
        .fpu_idle  (fpu_idle),
        .res_valid (res_valid),
        .res_e     (res_e),
        .res_m     (res_m),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- floating-point reference arithmetic ----------------
    function automatic real pow2(input int k);
        real r = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
        else        for (int i = 0; i < -k; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic logic [E_W+M_W-1:0] fcalc(input logic sub,
            input logic [E_W-1:0] ae, input logic [M_W-1:0] am,
            input logic [E_W-1:0] be, input logic [M_W-1:0] bm);
        real a, b, r;
        int  e, m, ea, eb;
        ea = int'($signed(ae));
        eb = int'($signed(be));
        a  = real'(am) * pow2(ea - (M_W - 1));
        b  = real'(bm) * pow2(eb - (M_W - 1));
        r  = sub ? (a - b) : (a + b);
        if (r <= 0.0) return '0;
        e = 0;
        while (r >= 2.0) begin r = r / 2.0; e++; end
        while (r < 1.0)  begin r = r * 2.0; e--; end
        m = $rtoi(r * pow2(M_W - 1));
        return {E_W'(e), M_W'(m)};
    endfunction

    // ---------------- FPU stub: 0 real, 1 stuck idle, 2 stuck busy ----------------
    int             fpu_mode = 0;
    int             f_st;
    int             f_cnt;
    logic           f_is_sub;
    logic [E_W-1:0] f_ae, f_be;
    logic [M_W-1:0] f_am, f_bm;

    // Sees a strobe, goes busy two edges after the strobe rose, stays busy
    // for 5 (add) or 6 (sub) cycles, then returns idle with the result.
    always @(posedge clk) begin
        if (reset) begin
            fpu_idle  <= 1'b1;
            f_st      <= 0;
            f_cnt     <= 0;
            fpu_res_e <= '0;
            fpu_res_m <= '0;
        end else if (fpu_mode == 1) begin
            fpu_idle <= 1'b1;
        end else if (fpu_mode == 2) begin
            fpu_idle <= 1'b0;
        end else begin
            case (f_st)
                0: if (fpu_add || fpu_sub) begin
                    f_st     <= 1;
                    f_is_sub <= fpu_sub;
                    f_ae     <= fpu_r1_e;
                    f_am     <= fpu_r1_m;
                    f_be     <= fpu_r2_e;
                    f_bm     <= fpu_r2_m;
                end
                1: begin
                    fpu_idle <= 1'b0;
                    f_cnt    <= f_is_sub ? 6 : 5;
                    f_st     <= 2;
                end
                default: begin
                    if (f_cnt == 1) begin
                        fpu_idle               <= 1'b1;
                        {fpu_res_e, fpu_res_m} <= fcalc(f_is_sub, f_ae, f_am, f_be, f_bm);
                        f_st                   <= 0;
                    end else begin
                        f_cnt <= f_cnt - 1;
                    end
                end
            endcase
        end
    end

    // ---------------- behavioural model: phase 0 idle, 1 issue, 2 wait, 3 write ----------------
    int                   ph;
    int                   pc;
    bit                   m_init = 1'b0;
    logic                 m_sub;
    logic                 m_err;
    logic [E_W+M_W-1:0]   m_r1, m_r2, m_res;

    always @(posedge clk) begin
        if (reset) begin
            ph     <= 0;
            pc     <= 0;
            m_sub  <= 1'b0;
            m_err  <= 1'b0;
            m_r1   <= '0;
            m_r2   <= '0;
            m_res  <= '0;
            m_init <= 1'b1;
        end else begin
            case (ph)
                0: if (cmd_valid) begin
                    if (cmd_op == 2'b00)      m_r1 <= {cmd_e, cmd_m};
                    else if (cmd_op == 2'b01) m_r2 <= {cmd_e, cmd_m};
                    else begin
                        m_sub <= cmd_op[0];
                        ph    <= 1;
                        pc    <= 0;
                    end
                end
                1: if (!fpu_idle) begin
                    ph <= 2;
                    pc <= 0;
                end else if (pc + 1 == START_TO) begin
                    m_err <= 1'b1;
                    ph    <= 0;
                end else begin
                    pc <= pc + 1;
                end
                2: if (fpu_idle) begin
                    m_r1  <= {fpu_res_e, fpu_res_m};
                    m_res <= {fpu_res_e, fpu_res_m};
                    ph    <= 3;
                end else if (pc + 1 == DONE_TO) begin
                    m_err <= 1'b1;
                    ph    <= 0;
                end else begin
                    pc <= pc + 1;
                end
                default: ph <= 0;
            endcase
        end
    end

    // Count result pulses at the edge that ends them
    always @(posedge clk) begin
        if (res_valid === 1'b1) pulses <= pulses + 1;
    end

    // Compare every DUT output against the model each cycle
    always @(negedge clk) begin
        if (m_init) begin
            chk("cmd_ready", cmd_ready, ph == 0);
            chk("busy", busy, ph != 0);
            chk("fpu_add", fpu_add, (ph == 1) && !m_sub);
            chk("fpu_sub", fpu_sub, (ph == 1) && m_sub);
            chk("strobe_exclusive", fpu_add & fpu_sub, 0);
            chk("res_valid", res_valid, ph == 3);
            chk("res", {res_e, res_m}, m_res);
            chk("err", err, m_err);
            chk("r1", {fpu_r1_e, fpu_r1_m}, m_r1);
            chk("r2", {fpu_r2_e, fpu_r2_m}, m_r2);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [1:0] op, input logic [E_W-1:0] e,
                        input logic [M_W-1:0] m, output int stall);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_e     = e;
        cmd_m     = m;
        stall     = 0;
        while (!cmd_ready && stall < 100) begin
            @(negedge clk);
            stall++;
        end
        if (!cmd_ready) chk("accept_timeout", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", busy, 0);
    endtask

    task automatic wait_res(output int cyc);
        cyc = 0;
        while (!res_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_err(output int cyc);
        cyc = 0;
        while (!err && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // ---------------- directed test sequence ----------------
    initial begin
        int st, cyc, p0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_e     = '0;
        cmd_m     = '0;

        // Pin the reference arithmetic itself
        chk("model_1p1", fcalc(1'b0, 7'd0, 15'h4000, 7'd0, 15'h4000), {7'd1, 15'h4000});
        chk("model_2m1", fcalc(1'b1, 7'd1, 15'h4000, 7'd0, 15'h4000), {7'd0, 15'h4000});
        chk("model_2p1", fcalc(1'b0, 7'd1, 15'h4000, 7'd0, 15'h4000), {7'd1, 15'h6000});

        // Reset
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_strobes", {fpu_add, fpu_sub, res_valid}, 0);
        chk("rst_regs", {fpu_r1_e, fpu_r1_m, fpu_r2_e, fpu_r2_m}, 0);
        chk("rst_res", {res_e, res_m}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Add 1.0 + 1.0
        p0 = pulses;
        send(2'b00, 7'd0, 15'h4000, st);
        send(2'b01, 7'd0, 15'h4000, st);
        chk("load_no_stall", st, 0);
        send(2'b10, 7'd0, 15'h0000, st);
        wait_res(cyc);
        chk("add_latency", cyc, 8);
        chk("add_within_12", cyc <= 12, 1);
        chk("add_res", {res_e, res_m}, {7'd1, 15'h4000});
        wait_idle();
        chk("add_r1", {fpu_r1_e, fpu_r1_m}, {7'd1, 15'h4000});
        chk("add_pulses", pulses - p0, 1);

        // Sub 2.0 - 1.0
        send(2'b00, 7'd1, 15'h4000, st);
        send(2'b01, 7'd0, 15'h4000, st);
        send(2'b11, 7'd0, 15'h0000, st);
        wait_res(cyc);
        chk("sub_latency", cyc, 9);
        chk("sub_res", {res_e, res_m}, {7'd0, 15'h4000});
        wait_idle();
        chk("sub_r2_kept", {fpu_r2_e, fpu_r2_m}, {7'd0, 15'h4000});

        // Back-to-back adds with cmd_valid held: 1 + 1 + 1 = 3
        send(2'b00, 7'd0, 15'h4000, st);
        p0 = pulses;
        send(2'b10, 7'd0, 15'h0000, st);
        send(2'b10, 7'd0, 15'h0000, st);
        chk("b2b_stalled", st > 0, 1);
        wait_idle();
        chk("b2b_r1", {fpu_r1_e, fpu_r1_m}, {7'd1, 15'h6000});
        chk("b2b_pulses", pulses - p0, 2);

        // Start timeout: FPU never leaves idle
        send(2'b00, 7'd2, 15'h5000, st);
        fpu_mode = 1;
        p0 = pulses;
        send(2'b10, 7'd0, 15'h0000, st);
        wait_err(cyc);
        chk("start_to_cycles", cyc, START_TO);
        chk("start_to_r1", {fpu_r1_e, fpu_r1_m}, {7'd2, 15'h5000});
        chk("start_to_strobes", {fpu_add, fpu_sub}, 0);
        chk("start_to_res", {res_e, res_m}, {7'd1, 15'h6000});
        chk("start_to_pulses", pulses - p0, 0);
        repeat (3) @(negedge clk);
        chk("err_sticky", err, 1);

        // Reset clears err; then done timeout: FPU never returns idle
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("err_cleared", err, 0);
        fpu_mode = 2;
        @(negedge clk);
        send(2'b11, 7'd0, 15'h0000, st);
        wait_err(cyc);
        chk("done_to_cycles", cyc, DONE_TO + 1);
        chk("done_to_idle", busy, 0);

        // Reset in the middle of WAIT
        reset    = 1'b1;
        fpu_mode = 0;
        @(negedge clk);
        reset = 1'b0;
        send(2'b00, 7'd0, 15'h4000, st);
        send(2'b01, 7'd0, 15'h4000, st);
        send(2'b10, 7'd0, 15'h0000, st);
        repeat (4) @(negedge clk);
        chk("mid_in_wait", {busy, fpu_add}, 2'b10);
        p0 = pulses;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_busy", busy, 0);
        chk("mid_res_valid", res_valid, 0);
        chk("mid_err", err, 0);
        chk("mid_r1", {fpu_r1_e, fpu_r1_m}, 0);
        repeat (15) @(negedge clk);
        chk("mid_no_pulse", pulses - p0, 0);
        chk("mid_no_err", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
